pic_ack_sequencer: RTL and testbench

//  Downstream stage of the 8259A priority resolver: takes the masked pending requests (IRR & ~IMR)
//  and the resolver's winning index, raises INT to the CPU, runs the two-pulse 8086 INTA cycle,

---
 rtl/pic_pkg.sv | 24 ++
 rtl/pic_isr_mask.sv | 16 +
 rtl/pic_ack_sequencer.sv | 145 ++++++++++++++
 tb/tb_pic_ack_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A-style interrupt acknowledge path.
package pic_pkg;

    localparam int IR_COUNT = 8;
    localparam int IDX_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK1 = 2'd2,
        ACK2 = 2'd3
    } pic_state_e;

    // Index of the lowest set bit (highest priority); 0 when the vector is empty.
    function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [IR_COUNT-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = IR_COUNT - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/pic_isr_mask.sv
// Lowest-set-bit finder on the In-Service Register; feeds nesting compare and non-specific EOI.
module pic_isr_mask
    import pic_pkg::*;
(
    input  logic [IR_COUNT-1:0] isr,
    output logic                isr_any,
    output logic [IDX_W-1:0]    isr_lowest,
    output logic [IR_COUNT-1:0] isr_lowest_onehot
);

    assign isr_any           = |isr;
    assign isr_lowest        = lowest_set_idx(isr);
    // Isolate the lowest set bit; yields zero when isr is empty.
    assign isr_lowest_onehot = isr & (~isr + IR_COUNT'(1));

endmodule

// File: rtl/pic_ack_sequencer.sv
// INT / two-pulse INTA sequencer with In-Service Register, vector drive and EOI handling.
module pic_ack_sequencer
    import pic_pkg::*;
#(
    parameter int              AUTO_EOI     = 0,
    parameter logic [IDX_W-1:0] SPURIOUS_IDX = 3'd7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IR_COUNT-1:0] pending_irq,
    input  logic [IDX_W-1:0]    resolved_index,
    input  logic                inta_n,
    input  logic                eoi_valid,
    input  logic                eoi_specific,
    input  logic [IDX_W-1:0]    eoi_level,
    input  logic [4:0]          vector_base,
    output logic                int_out,
    output logic [IR_COUNT-1:0] irr_clear,
    output logic [IR_COUNT-1:0] isr,
    output logic [7:0]          data_out,
    output logic                data_oe
);

    pic_state_e          state_reg, state_next;
    logic                inta_q;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic                spurious_reg, spurious_next;
    logic [IR_COUNT-1:0] isr_reg, isr_next;
    logic                int_reg, int_next;
    logic [IR_COUNT-1:0] irr_clear_reg, irr_clear_next;
    logic [7:0]          data_out_reg, data_out_next;
    logic                data_oe_reg, data_oe_next;

    logic                isr_any;
    logic [IDX_W-1:0]    isr_lowest;
    logic [IR_COUNT-1:0] isr_lowest_onehot;
    logic [IR_COUNT-1:0] set_vec, aeoi_clr, eoi_clr;
    logic                inta_fall, inta_rise, eligible;

    pic_isr_mask u_isr_mask (
        .isr               (isr_reg),
        .isr_any           (isr_any),
        .isr_lowest        (isr_lowest),
        .isr_lowest_onehot (isr_lowest_onehot)
    );

    assign inta_fall = inta_q & ~inta_n;
    assign inta_rise = ~inta_q & inta_n;
    assign eligible  = (|pending_irq) && (!isr_any || (resolved_index < isr_lowest));

    always_comb begin
        eoi_clr = '0;
        if (eoi_valid) begin
            eoi_clr = eoi_specific ? (IR_COUNT'(1) << eoi_level) : isr_lowest_onehot;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        spurious_next  = spurious_reg;
        int_next       = int_reg;
        irr_clear_next = '0;
        data_out_next  = data_out_reg;
        data_oe_next   = data_oe_reg;
        set_vec        = '0;
        aeoi_clr       = '0;
        case (state_reg)
            IDLE: begin
                if (eligible) begin
                    state_next = REQ;
                    int_next   = 1'b1;
                end
            end
            REQ: begin
                if (inta_fall) begin
                    state_next = ACK1;
                    int_next   = 1'b0;
                    if (|pending_irq) begin
                        idx_next       = resolved_index;
                        spurious_next  = 1'b0;
                        set_vec        = IR_COUNT'(1) << resolved_index;
                        irr_clear_next = IR_COUNT'(1) << resolved_index;
                    end else begin
                        // Request withdrawn before acknowledge: hand out the spurious vector.
                        idx_next      = SPURIOUS_IDX;
                        spurious_next = 1'b1;
                    end
                end
            end
            ACK1: begin
                // A falling edge here implies the first pulse has already risen.
                if (inta_fall) begin
                    state_next    = ACK2;
                    data_out_next = {vector_base, idx_reg};
                    data_oe_next  = 1'b1;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    state_next    = IDLE;
                    data_out_next = '0;
                    data_oe_next  = 1'b0;
                    if ((AUTO_EOI != 0) && !spurious_reg) begin
                        aeoi_clr = IR_COUNT'(1) << idx_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // Set beats a same-cycle clear of the same bit; distinct bits both apply.
        isr_next = (isr_reg & ~(eoi_clr | aeoi_clr)) | set_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            inta_q        <= 1'b1;
            idx_reg       <= '0;
            spurious_reg  <= 1'b0;
            isr_reg       <= '0;
            int_reg       <= 1'b0;
            irr_clear_reg <= '0;
            data_out_reg  <= '0;
            data_oe_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            inta_q        <= inta_n;
            idx_reg       <= idx_next;
            spurious_reg  <= spurious_next;
            isr_reg       <= isr_next;
            int_reg       <= int_next;
            irr_clear_reg <= irr_clear_next;
            data_out_reg  <= data_out_next;
            data_oe_reg   <= data_oe_next;
        end
    end

    assign int_out   = int_reg;
    assign irr_clear = irr_clear_reg;
    assign isr       = isr_reg;
    assign data_out  = data_out_reg;
    assign data_oe   = data_oe_reg;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Directed bench: cycle-by-cycle vector table for normal/AEOI DUTs plus a mid-sequence reset case.
module tb_pic_ack_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pending_irq;
    logic [2:0] resolved_index;
    logic       inta_n;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic [4:0] vector_base;

    logic       int_out, data_oe;
    logic [7:0] irr_clear, isr, data_out;
    logic       a_int_out, a_data_oe;
    logic [7:0] a_irr_clear, a_isr, a_data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pic_ack_sequencer #(.AUTO_EOI(0), .SPURIOUS_IDX(3'd7)) dut (
        .clk(clk), .rst_n(rst_n), .pending_irq(pending_irq), .resolved_index(resolved_index),
        .inta_n(inta_n), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .vector_base(vector_base), .int_out(int_out), .irr_clear(irr_clear), .isr(isr),
        .data_out(data_out), .data_oe(data_oe)
    );

    pic_ack_sequencer #(.AUTO_EOI(1), .SPURIOUS_IDX(3'd7)) dut_aeoi (
        .clk(clk), .rst_n(rst_n), .pending_irq(pending_irq), .resolved_index(resolved_index),
        .inta_n(inta_n), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .vector_base(vector_base), .int_out(a_int_out), .irr_clear(a_irr_clear), .isr(a_isr),
        .data_out(a_data_out), .data_oe(a_data_oe)
    );

    typedef struct {
        logic [7:0] pend;
        logic [2:0] ridx;
        logic       inta;
        logic       eoi;
        logic       spec;
        logic [2:0] lvl;
        logic       exp_int;
        logic [7:0] exp_irrc;
        logic [7:0] exp_isr;
        logic [7:0] exp_dout;
        logic       exp_doe;
        logic [7:0] exp_isr_a;
    } vec_t;

    localparam int NVEC = 30;
    vec_t tbl[NVEC];

    function automatic vec_t mk(input logic [7:0] pend, input logic [2:0] ridx, input logic inta,
                                input logic eoi, input logic spec, input logic [2:0] lvl,
                                input logic e_int, input logic [7:0] e_irrc, input logic [7:0] e_isr,
                                input logic [7:0] e_dout, input logic e_doe, input logic [7:0] e_isra);
        vec_t v;
        v.pend = pend; v.ridx = ridx; v.inta = inta; v.eoi = eoi; v.spec = spec; v.lvl = lvl;
        v.exp_int = e_int; v.exp_irrc = e_irrc; v.exp_isr = e_isr;
        v.exp_dout = e_dout; v.exp_doe = e_doe; v.exp_isr_a = e_isra;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [7:0] p, input logic [2:0] r, input logic ia);
        @(negedge clk);
        pending_irq = p; resolved_index = r; inta_n = ia;
        eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // test 1: basic two-pulse acknowledge of IR3
        tbl[0]  = mk(8'h08, 3'd3, 1, 0, 0, 3'd0,  1, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        tbl[1]  = mk(8'h08, 3'd3, 0, 0, 0, 3'd0,  0, 8'h08, 8'h08, 8'h00, 0, 8'h08);
        tbl[2]  = mk(8'h00, 3'd0, 0, 0, 0, 3'd0,  0, 8'h00, 8'h08, 8'h00, 0, 8'h08);
        tbl[3]  = mk(8'h00, 3'd0, 1, 0, 0, 3'd0,  0, 8'h00, 8'h08, 8'h00, 0, 8'h08);
        tbl[4]  = mk(8'h00, 3'd0, 0, 0, 0, 3'd0,  0, 8'h00, 8'h08, 8'h43, 1, 8'h08);
        tbl[5]  = mk(8'h00, 3'd0, 0, 0, 0, 3'd0,  0, 8'h00, 8'h08, 8'h43, 1, 8'h08);
        tbl[6]  = mk(8'h00, 3'd0, 1, 0, 0, 3'd0,  0, 8'h00, 8'h08, 8'h00, 0, 8'h00);
        tbl[7]  = mk(8'h00, 3'd0, 1, 0, 0, 3'd0,  0, 8'h00, 8'h08, 8'h00, 0, 8'h00);
        // test 2: lower priority blocked, higher priority nests
        tbl[8]  = mk(8'h20, 3'd5, 1, 0, 0, 3'd0,  0, 8'h00, 8'h08, 8'h00, 0, 8'h00);
        tbl[9]  = mk(8'h20, 3'd5, 1, 0, 0, 3'd0,  0, 8'h00, 8'h08, 8'h00, 0, 8'h00);
        tbl[10] = mk(8'h02, 3'd1, 1, 0, 0, 3'd0,  1, 8'h00, 8'h08, 8'h00, 0, 8'h00);
        tbl[11] = mk(8'h02, 3'd1, 0, 0, 0, 3'd0,  0, 8'h02, 8'h0A, 8'h00, 0, 8'h02);
        tbl[12] = mk(8'h00, 3'd0, 1, 0, 0, 3'd0,  0, 8'h00, 8'h0A, 8'h00, 0, 8'h02);
        tbl[13] = mk(8'h00, 3'd0, 0, 0, 0, 3'd0,  0, 8'h00, 8'h0A, 8'h41, 1, 8'h02);
        tbl[14] = mk(8'h00, 3'd0, 1, 0, 0, 3'd0,  0, 8'h00, 8'h0A, 8'h00, 0, 8'h00);
        // test 3: EOI variants
        tbl[15] = mk(8'h00, 3'd0, 1, 1, 0, 3'd0,  0, 8'h00, 8'h08, 8'h00, 0, 8'h00);
        tbl[16] = mk(8'h00, 3'd0, 1, 1, 1, 3'd3,  0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        tbl[17] = mk(8'h00, 3'd0, 1, 1, 0, 3'd0,  0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        // test 4: request withdrawn before acknowledge -> spurious vector
        tbl[18] = mk(8'h10, 3'd4, 1, 0, 0, 3'd0,  1, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        tbl[19] = mk(8'h00, 3'd0, 1, 0, 0, 3'd0,  1, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        tbl[20] = mk(8'h00, 3'd0, 0, 0, 0, 3'd0,  0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        tbl[21] = mk(8'h00, 3'd0, 1, 0, 0, 3'd0,  0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        tbl[22] = mk(8'h00, 3'd0, 0, 0, 0, 3'd0,  0, 8'h00, 8'h00, 8'h47, 1, 8'h00);
        tbl[23] = mk(8'h00, 3'd0, 1, 0, 0, 3'd0,  0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        // test 5: IR0 with AEOI comparison; specific EOI on the bit being set loses
        tbl[24] = mk(8'h01, 3'd0, 1, 0, 0, 3'd0,  1, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        tbl[25] = mk(8'h01, 3'd0, 0, 1, 1, 3'd0,  0, 8'h01, 8'h01, 8'h00, 0, 8'h01);
        tbl[26] = mk(8'h00, 3'd0, 1, 0, 0, 3'd0,  0, 8'h00, 8'h01, 8'h00, 0, 8'h01);
        tbl[27] = mk(8'h00, 3'd0, 0, 0, 0, 3'd0,  0, 8'h00, 8'h01, 8'h40, 1, 8'h01);
        tbl[28] = mk(8'h00, 3'd0, 1, 0, 0, 3'd0,  0, 8'h00, 8'h01, 8'h00, 0, 8'h00);
        tbl[29] = mk(8'h00, 3'd0, 1, 1, 0, 3'd0,  0, 8'h00, 8'h00, 8'h00, 0, 8'h00);

        rst_n = 1'b0; pending_irq = '0; resolved_index = '0; inta_n = 1'b1;
        eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = '0; vector_base = 5'h08;
        repeat (3) @(posedge clk);
        #1;
        chk("reset int_out", {7'd0, int_out}, 8'h00);
        chk("reset irr_clear", irr_clear, 8'h00);
        chk("reset isr", isr, 8'h00);
        chk("reset data_out", data_out, 8'h00);
        chk("reset data_oe", {7'd0, data_oe}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            pending_irq = tbl[i].pend; resolved_index = tbl[i].ridx; inta_n = tbl[i].inta;
            eoi_valid = tbl[i].eoi; eoi_specific = tbl[i].spec; eoi_level = tbl[i].lvl;
            @(posedge clk);
            #1;
            $display("vec %0d: pend=%02h inta=%b eoi=%b -> int=%b irrc=%02h isr=%02h dout=%02h oe=%b isr_aeoi=%02h",
                     i, tbl[i].pend, tbl[i].inta, tbl[i].eoi, int_out, irr_clear, isr, data_out, data_oe, a_isr);
            chk($sformatf("vec%0d int_out", i), {7'd0, int_out}, {7'd0, tbl[i].exp_int});
            chk($sformatf("vec%0d irr_clear", i), irr_clear, tbl[i].exp_irrc);
            chk($sformatf("vec%0d isr", i), isr, tbl[i].exp_isr);
            chk($sformatf("vec%0d data_out", i), data_out, tbl[i].exp_dout);
            chk($sformatf("vec%0d data_oe", i), {7'd0, data_oe}, {7'd0, tbl[i].exp_doe});
            chk($sformatf("vec%0d isr_aeoi", i), a_isr, tbl[i].exp_isr_a);
        end

        // test 6: asynchronous reset between INTA pulses, then a fresh sequence
        step(8'h04, 3'd2, 1'b1);
        chk("t6 int raised", {7'd0, int_out}, 8'h01);
        step(8'h04, 3'd2, 1'b0);
        chk("t6 isr set", isr, 8'h04);
        step(8'h00, 3'd0, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("t6 async reset: int=%b irrc=%02h isr=%02h dout=%02h oe=%b", int_out, irr_clear, isr, data_out, data_oe);
        chk("t6 rst int_out", {7'd0, int_out}, 8'h00);
        chk("t6 rst irr_clear", irr_clear, 8'h00);
        chk("t6 rst isr", isr, 8'h00);
        chk("t6 rst data_out", data_out, 8'h00);
        chk("t6 rst data_oe", {7'd0, data_oe}, 8'h00);
        chk("t6 rst isr_aeoi", a_isr, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h04, 3'd2, 1'b1);
        chk("t6 re int_out", {7'd0, int_out}, 8'h01);
        step(8'h04, 3'd2, 1'b0);
        chk("t6 re irr_clear", irr_clear, 8'h04);
        chk("t6 re isr", isr, 8'h04);
        chk("t6 re int low", {7'd0, int_out}, 8'h00);
        step(8'h00, 3'd0, 1'b1);
        chk("t6 re oe idle", {7'd0, data_oe}, 8'h00);
        step(8'h00, 3'd0, 1'b0);
        chk("t6 re data_out", data_out, 8'h42);
        chk("t6 re data_oe", {7'd0, data_oe}, 8'h01);
        step(8'h00, 3'd0, 1'b1);
        chk("t6 re oe end", {7'd0, data_oe}, 8'h00);
        chk("t6 re isr end", isr, 8'h04);
        chk("t6 re isr_aeoi end", a_isr, 8'h00);
        $display("t6 resequence: isr=%02h isr_aeoi=%02h", isr, a_isr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
